ofmi_addr_counter: RTL
======================

OFMI_ADDR_COUNTER -- requirements
Module: ofmi_addr_counter

Interface
REQ-001 Parameter ADDR_W, 16, width of addresses, counts and config data.
REQ-002 Parameter LIM0_RST, 16'd9, reset value of read limit register LIM0 (weight words).
REQ-003 Parameter LIM1_RST, 16'd0, reset value of write limit register LIM1.
REQ-004 OFMI_ADDR_COUNTER_Clk  in  1  single clock; all state updates on rising edge.
REQ-005 OFMI_ADDR_COUNTER_Reset  in  1  reset is synchronous and active-low.
REQ-006 OFMI_ADDR_COUNTER_Cfg_We  in  1  config write strobe.
REQ-007 OFMI_ADDR_COUNTER_Cfg_Sel  in  2  config target: 0=BASE0, 1=BASE1, 2=LIM0, 3=LIM1.
REQ-008 OFMI_ADDR_COUNTER_Cfg_Data  in  ADDR_W  config write data.
REQ-009 OFMI_ADDR_COUNTER_Sel_Offset  in  1  base select: 0=BASE0 (weights), 1=BASE1 (feature data).
REQ-010 OFMI_ADDR_COUNTER_Sel_UpperLim  in  1  limit select: 0=LIM0 (read), 1=LIM1 (write).
REQ-011 OFMI_ADDR_COUNTER_En  in  1  count enable.
REQ-012 OFMI_ADDR_COUNTER_Clear_n  in  1  active-low synchronous count clear from the interface state machine.
REQ-013 OFMI_ADDR_COUNTER_Addr  out  ADDR_W  off-chip memory address.
REQ-014 OFMI_ADDR_COUNTER_Count  out  ADDR_W  current word index.
REQ-015 OFMI_ADDR_COUNTER_Finish  out  1  terminal index reached.
REQ-016 OFMI_ADDR_COUNTER_Cfg_Err  out  1  sticky flag: config write attempted while counting.

Function
REQ-017 Registers: COUNT, BASE0, BASE1, LIM0, LIM1, CFG_ERR; no other state.
REQ-018 LAST = selected limit minus 1; a selected limit of 0 SHALL be treated as 1 (LAST=0).
REQ-019 Priority per edge: Reset, then Clear_n=0 (COUNT<=0), then En=1 counting, else hold.
REQ-020 Counting: if COUNT != LAST then COUNT<=COUNT+1; if COUNT == LAST then COUNT holds (saturates, never wraps).
REQ-021 COUNT > LAST (limit lowered mid-run) SHALL hold COUNT and assert Finish.
REQ-022 Finish = Clear_n AND (COUNT >= LAST), combinational from registered COUNT and current selects; no extra latency.
REQ-023 Addr = selected base + COUNT, modulo 2^ADDR_W (address wrap permitted); combinational from registers and Sel_Offset.
REQ-024 Count output = COUNT directly.
REQ-025 En=0 with Clear_n=1 holds COUNT (pause/resume of feeding); resume continues from held index.
REQ-026 Select inputs changing mid-count take effect on Addr/Finish the same cycle; COUNT unaffected.
REQ-027 Cfg_We=1 writes Cfg_Data to the register chosen by Cfg_Sel at the edge; visible the following cycle.
REQ-028 Cfg_We=1 while Clear_n=1 AND En=1 SHALL still perform the write and set CFG_ERR; CFG_ERR clears only on Reset.
REQ-029 Cfg_We=1 coincident with Clear_n=0 is a legal write, no error.

Reset
REQ-030 Reset=0 at an edge: COUNT=0, BASE0=0, BASE1=0, LIM0=LIM0_RST, LIM1=LIM1_RST, CFG_ERR=0; overrides Clear_n, En, Cfg_We.
REQ-031 After reset: Count=0, Addr=0, Cfg_Err=0, Finish=Clear_n AND (LAST==0).
REQ-032 Reset mid-count discards progress; next run starts at index 0 with reset config.

Verification
REQ-033 Reset, write BASE0=0x0100, LIM0=9, Clear_n=1, En=1 for 12 cycles -> Addr 0x0100..0x0108, Finish high from COUNT=8, COUNT holds 8.
REQ-034 Sel_Offset=1, BASE1=0x2000, LIM0=5; En high 2 cycles, low 3, high again -> COUNT 0,1,2,2,2,2,3,4 hold; Finish only at COUNT=4.
REQ-035 Clear_n=0 and En=1 same cycle at COUNT=6 -> COUNT=0 next cycle; Finish low while Clear_n=0.
REQ-036 BASE1=0xFFFE, COUNT reaches 3 -> Addr 0xFFFE,0xFFFF,0x0000,0x0001 (wrap).
REQ-037 LIM1=0 with Sel_UpperLim=1 -> Finish high at COUNT=0, COUNT never increments; LIM0 lowered to 2 at COUNT=5 -> Finish high, COUNT holds 5.
REQ-038 Cfg_We while counting -> register updated, Cfg_Err=1 sticky; Reset=0 -> Cfg_Err=0, LIM0=9.

Source files
------------

// File: rtl/ofmi_addr_counter.sv
// Off-chip memory address counter: walks a word index from 0 up to a programmable
// terminal index, adding a selectable base to form the memory address.
module ofmi_addr_counter #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] LIM0_RST = 16'd9,
    parameter logic [ADDR_W-1:0] LIM1_RST = 16'd0
) (
    input  logic              OFMI_ADDR_COUNTER_Clk,
    input  logic              OFMI_ADDR_COUNTER_Reset,
    input  logic              OFMI_ADDR_COUNTER_Cfg_We,
    input  logic [1:0]        OFMI_ADDR_COUNTER_Cfg_Sel,
    input  logic [ADDR_W-1:0] OFMI_ADDR_COUNTER_Cfg_Data,
    input  logic              OFMI_ADDR_COUNTER_Sel_Offset,
    input  logic              OFMI_ADDR_COUNTER_Sel_UpperLim,
    input  logic              OFMI_ADDR_COUNTER_En,
    input  logic              OFMI_ADDR_COUNTER_Clear_n,
    output logic [ADDR_W-1:0] OFMI_ADDR_COUNTER_Addr,
    output logic [ADDR_W-1:0] OFMI_ADDR_COUNTER_Count,
    output logic              OFMI_ADDR_COUNTER_Finish,
    output logic              OFMI_ADDR_COUNTER_Cfg_Err
);

    localparam logic [1:0] SEL_BASE0 = 2'd0;
    localparam logic [1:0] SEL_BASE1 = 2'd1;
    localparam logic [1:0] SEL_LIM0  = 2'd2;
    localparam logic [1:0] SEL_LIM1  = 2'd3;

    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_base0;
    logic [ADDR_W-1:0] r_base1;
    logic [ADDR_W-1:0] r_lim0;
    logic [ADDR_W-1:0] r_lim1;
    logic              r_cfg_err;

    logic [ADDR_W-1:0] w_limit;
    logic [ADDR_W-1:0] w_last;
    logic [ADDR_W-1:0] w_base;
    logic              w_at_end;
    logic              w_counting;

    // A limit of zero behaves as a limit of one so LAST never underflows.
    always_comb begin
        w_limit = OFMI_ADDR_COUNTER_Sel_UpperLim ? r_lim1 : r_lim0;
        if (w_limit == '0) begin
            w_last = '0;
        end else begin
            w_last = w_limit - 1'b1;
        end
        w_base     = OFMI_ADDR_COUNTER_Sel_Offset ? r_base1 : r_base0;
        w_at_end   = (r_count >= w_last);
        w_counting = OFMI_ADDR_COUNTER_Clear_n & OFMI_ADDR_COUNTER_En;
    end

    always_ff @(posedge OFMI_ADDR_COUNTER_Clk) begin
        if (!OFMI_ADDR_COUNTER_Reset) begin
            r_count   <= '0;
            r_base0   <= '0;
            r_base1   <= '0;
            r_lim0    <= LIM0_RST;
            r_lim1    <= LIM1_RST;
            r_cfg_err <= 1'b0;
        end else begin
            // Saturate at LAST; an index already past a lowered limit simply holds.
            if (!OFMI_ADDR_COUNTER_Clear_n) begin
                r_count <= '0;
            end else if (OFMI_ADDR_COUNTER_En && !w_at_end) begin
                r_count <= r_count + 1'b1;
            end

            if (OFMI_ADDR_COUNTER_Cfg_We) begin
                case (OFMI_ADDR_COUNTER_Cfg_Sel)
                    SEL_BASE0: r_base0 <= OFMI_ADDR_COUNTER_Cfg_Data;
                    SEL_BASE1: r_base1 <= OFMI_ADDR_COUNTER_Cfg_Data;
                    SEL_LIM0:  r_lim0  <= OFMI_ADDR_COUNTER_Cfg_Data;
                    SEL_LIM1:  r_lim1  <= OFMI_ADDR_COUNTER_Cfg_Data;
                    default:   r_lim1  <= r_lim1;
                endcase
                if (w_counting) begin
                    r_cfg_err <= 1'b1;
                end
            end
        end
    end

    assign OFMI_ADDR_COUNTER_Addr    = w_base + r_count;
    assign OFMI_ADDR_COUNTER_Count   = r_count;
    assign OFMI_ADDR_COUNTER_Finish  = OFMI_ADDR_COUNTER_Clear_n & w_at_end;
    assign OFMI_ADDR_COUNTER_Cfg_Err = r_cfg_err;

endmodule
